// File: rtl/psum_accumulator.sv
// Resolves redundant sum/carry beats from the multiplier array and accumulates them with
// signed saturation into one dot-product result, presented behind a valid/ready handshake.
module psum_accumulator #(
   parameter int unsigned IN_SIZE  = 20,
   parameter int unsigned ACC_SIZE = 32,
   parameter int unsigned LEN_SIZE = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                start_i,
   input  logic [LEN_SIZE-1:0] len_i,
   input  logic [IN_SIZE-1:0]  in_i [0:1],
   input  logic                in_valid_i,
   output logic                in_ready_o,
   output logic [ACC_SIZE-1:0] out_o,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic                overflow_o,
   output logic                busy_o
);

   typedef enum logic [1:0] {
      StIdle,
      StAccum,
      StDone
   } state_e;

   state_e              state_q, state_d;
   logic [ACC_SIZE-1:0] acc_q, acc_d;
   logic [LEN_SIZE-1:0] cnt_q, cnt_d;
   logic [LEN_SIZE-1:0] len_q, len_d;
   logic                ovf_q, ovf_d;

   logic signed [IN_SIZE-1:0]  beat_s;
   logic signed [ACC_SIZE-1:0] beat_ext;
   logic [ACC_SIZE:0]          acc_sum;
   logic                       sat_pos, sat_neg;
   logic [ACC_SIZE-1:0]        acc_sat;
   logic                       last_beat;

   // Carry-propagate resolve; the wrap modulo 2^IN_SIZE is intentional.
   assign beat_s   = in_i[0] + in_i[1];
   assign beat_ext = ACC_SIZE'(beat_s);

   // One guard bit: overflow when the two top bits of the widened sum disagree.
   assign acc_sum = {acc_q[ACC_SIZE-1], acc_q} + {beat_ext[ACC_SIZE-1], beat_ext};
   assign sat_pos = ~acc_sum[ACC_SIZE] & acc_sum[ACC_SIZE-1];
   assign sat_neg = acc_sum[ACC_SIZE] & ~acc_sum[ACC_SIZE-1];

   always_comb begin
      acc_sat = acc_sum[ACC_SIZE-1:0];
      if (sat_pos) begin
         acc_sat = {1'b0, {(ACC_SIZE-1){1'b1}}};
      end else if (sat_neg) begin
         acc_sat = {1'b1, {(ACC_SIZE-1){1'b0}}};
      end
   end

   assign last_beat = (cnt_q == len_q - LEN_SIZE'(1));

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               acc_d = '0;
               cnt_d = '0;
               ovf_d = 1'b0;
               if (len_i != '0) begin
                  len_d   = len_i;
                  state_d = StAccum;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StAccum: begin
            if (in_valid_i) begin
               acc_d = acc_sat;
               ovf_d = ovf_q | sat_pos | sat_neg;
               cnt_d = cnt_q + LEN_SIZE'(1);
               if (last_beat) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            if (out_ready_i) begin
               state_d = StIdle;
               // A start in the handshake cycle relaunches without an idle bubble.
               if (start_i) begin
                  acc_d = '0;
                  cnt_d = '0;
                  ovf_d = 1'b0;
                  if (len_i != '0) begin
                     len_d   = len_i;
                     state_d = StAccum;
                  end else begin
                     state_d = StDone;
                  end
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         acc_q   <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         ovf_q   <= ovf_d;
      end
   end

   assign out_o       = acc_q;
   assign out_valid_o = (state_q == StDone);
   assign in_ready_o  = (state_q == StAccum);
   assign overflow_o  = ovf_q;
   assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_psum_accumulator.sv
// Drives two accumulator widths (32 and 20 bits) with the same beats and compares each
// against a saturating-integer reference computed per transaction.
module tb_psum_accumulator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  len_v = '0;
   logic [19:0] in_v [0:1];
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;

   logic        in_ready_a, out_valid_a, overflow_a, busy_a;
   logic [31:0] out_a;
   logic        in_ready_b, out_valid_b, overflow_b, busy_b;
   logic [19:0] out_b;

   int n_vec = 0;
   int n_err = 0;

   logic [19:0] bs [0:255];
   logic [19:0] bc [0:255];

   always #5 clk = ~clk;

   psum_accumulator #(.IN_SIZE(20), .ACC_SIZE(32), .LEN_SIZE(8)) u_dut_a (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .start_i    (start),
      .len_i      (len_v),
      .in_i       (in_v),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready_a),
      .out_o      (out_a),
      .out_valid_o(out_valid_a),
      .out_ready_i(out_ready),
      .overflow_o (overflow_a),
      .busy_o     (busy_a)
   );

   psum_accumulator #(.IN_SIZE(20), .ACC_SIZE(20), .LEN_SIZE(8)) u_dut_b (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .start_i    (start),
      .len_i      (len_v),
      .in_i       (in_v),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready_b),
      .out_o      (out_b),
      .out_valid_o(out_valid_b),
      .out_ready_i(out_ready),
      .overflow_o (overflow_b),
      .busy_o     (busy_b)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic longint beat_val(input logic [19:0] s, input logic [19:0] c);
      logic signed [19:0] r;
      r = s + c;
      return longint'(r);
   endfunction

   function automatic longint clamp(input longint t, input int w);
      longint mx;
      longint mn;
      mx = (longint'(1) <<< (w - 1)) - 1;
      mn = -mx - 1;
      if (t > mx) return mx;
      if (t < mn) return mn;
      return t;
   endfunction

   task automatic check_done(input string tag, input longint ea, input bit oa,
                             input longint eb, input bit ob);
      logic [31:0] xa;
      logic [19:0] xb;
      xa = ea[31:0];
      xb = eb[19:0];
      check({tag, ".vld_a"}, 64'(out_valid_a), 64'(1));
      check({tag, ".vld_b"}, 64'(out_valid_b), 64'(1));
      check({tag, ".out_a"}, 64'(out_a), 64'(xa));
      check({tag, ".out_b"}, 64'(out_b), 64'(xb));
      check({tag, ".ovf_a"}, 64'(overflow_a), 64'(oa));
      check({tag, ".ovf_b"}, 64'(overflow_b), 64'(ob));
      check({tag, ".rdy"}, 64'({in_ready_a, in_ready_b}), 64'(0));
      check({tag, ".busy"}, 64'({busy_a, busy_b}), 64'(3));
   endtask

   // vmode: 0 = always valid, 1 = random valid, 2 = toggling valid starting high.
   task automatic run_txn(input int len, input int vmode, input int hold, input string tag);
      longint ea, eb, t;
      bit     oa, ob;
      int     k, guard;
      ea = 0; eb = 0; oa = 0; ob = 0;
      start = 1'b1;
      len_v = len[7:0];
      @(posedge clk); #1;
      start = 1'b0;
      len_v = 8'($urandom);
      k = 0;
      guard = 0;
      while (k < len && guard < 2000) begin
         check({tag, ".acc_rdy"}, 64'({in_ready_a, in_ready_b}), 64'(3));
         check({tag, ".acc_vld"}, 64'({out_valid_a, out_valid_b}), 64'(0));
         case (vmode)
            0:       in_valid = 1'b1;
            1:       in_valid = 1'($urandom_range(0, 1));
            default: in_valid = (guard % 2 == 0);
         endcase
         in_v[0] = in_valid ? bs[k] : 20'($urandom);
         in_v[1] = in_valid ? bc[k] : 20'($urandom);
         @(posedge clk); #1;
         if (in_valid) begin
            t  = ea + beat_val(bs[k], bc[k]);
            ea = clamp(t, 32);
            oa = oa | (ea != t);
            t  = eb + beat_val(bs[k], bc[k]);
            eb = clamp(t, 20);
            ob = ob | (eb != t);
            k++;
         end
         guard++;
      end
      check({tag, ".beats"}, 64'(k), 64'(len));
      // Offer junk while done; it must not be consumed.
      in_valid = 1'b1;
      in_v[0]  = 20'($urandom);
      in_v[1]  = 20'($urandom);
      check_done(tag, ea, oa, eb, ob);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check_done({tag, ".hold"}, ea, oa, eb, ob);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, ".idle"}, 64'({out_valid_a, out_valid_b, busy_a, busy_b}), 64'(0));
   endtask

   initial begin
      in_v[0] = '0;
      in_v[1] = '0;
      #3;
      check("reset", 64'({out_a, out_valid_a, in_ready_a, overflow_a, busy_a}), 64'(0));
      check("reset_b", 64'({out_b, out_valid_b, in_ready_b, overflow_b, busy_b}), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      bs[0] = 20'h00005; bc[0] = 20'h00003; bs[1] = 20'h00010; bc[1] = 20'h00000;
      run_txn(2, 0, 0, "basic");

      bs[0] = 20'hFFFFF; bc[0] = 20'hFFFFE;
      run_txn(1, 0, 0, "negwrap");
      bs[0] = 20'h80000; bc[0] = 20'h80000;
      run_txn(1, 0, 0, "zero");

      for (int i = 0; i < 3; i++) begin bs[i] = 20'h1; bc[i] = 20'h0; end
      run_txn(3, 2, 4, "stall");

      bs[0] = 20'h3FFFF; bc[0] = 20'h40000; bs[1] = 20'h3FFFF; bc[1] = 20'h40000;
      run_txn(2, 0, 1, "sat");
      bs[0] = 20'h1; bc[0] = 20'h0;
      run_txn(1, 0, 0, "unsat");

      // len=0 then relaunch in the handshake cycle.
      start = 1'b1; len_v = 8'd0; in_valid = 1'b1; in_v[0] = 20'h9; in_v[1] = 20'h0;
      @(posedge clk); #1;
      start = 1'b0;
      check_done("len0", 0, 1'b0, 0, 1'b0);
      out_ready = 1'b1; start = 1'b1; len_v = 8'd1; in_valid = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b0; start = 1'b0;
      check("chain.state", 64'({in_ready_a, out_valid_a, busy_a}), 64'(3'b101));
      in_valid = 1'b1; in_v[0] = 20'h4; in_v[1] = 20'h3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_done("chain", 7, 1'b0, 7, 1'b0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Asynchronous reset after two of four beats.
      start = 1'b1; len_v = 8'd4;
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b1; in_v[0] = 20'h11; in_v[1] = 20'h22;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_a", 64'({out_a, out_valid_a, in_ready_a, overflow_a, busy_a}), 64'(0));
      check("rst_async_b", 64'({out_b, out_valid_b, in_ready_b, overflow_b, busy_b}), 64'(0));
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("rst_quiet", 64'({out_valid_a, out_valid_b, busy_a, busy_b}), 64'(0));
      end
      bs[0] = 20'h2; bc[0] = 20'h3;
      run_txn(1, 0, 0, "post_rst");

      for (int n = 0; n < 30; n++) begin
         int len;
         len = (n % 7 == 0) ? 0 : int'($urandom_range(1, 12));
         for (int i = 0; i < len; i++) begin
            bs[i] = 20'($urandom);
            bc[i] = 20'($urandom);
         end
         run_txn(len, 1, int'($urandom_range(0, 3)), $sformatf("rnd%0d", n));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
